out_display_unit: RTL and testbench
===================================

# out_display_unit

Output stage fed by the processor's OUT path. On each OUT instruction it captures the emitted value into one of eight 16-bit output slots. It holds the latest second-operand value on a 16-bit LED bank, and time-multiplexes two selected slots onto an 8-digit, active-low 7-segment display as hexadecimal. It sits directly downstream of `processor`: it consumes `outval1`, `outval2`, `outsel` and `outdisplay`.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each digit stays lit; legal range 2..2^20.
- `clock`  in  1: single clock domain; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high.
- `outval1`  in  16: value captured into the selected slot.
- `outval2`  in  16: value copied to `led`.
- `outsel`  in  3: slot index for the capture.
- `outdisplay`  in  1: one-cycle strobe; a capture occurs on every cycle it is high.
- `page_sel`  in  2: display page; page p shows slot 2p+1 on digits 7..4 and slot 2p on digits 3..0.
- `seg`  out  8: segments {dp,g,f,e,d,c,b,a}, active-low, registered.
- `digit_sel`  out  8: digit anodes, one-hot active-low, registered.
- `led`  out  16: last `outval2` captured, registered.
- `out_count`  out  16: number of OUT strobes since reset, wraps, registered.

## Operation
- Capture, on any edge with `outdisplay`=1:
  - `slot[outsel]` <= `outval1`.
  - `valid[outsel]` <= 1.
  - `led` <= `outval2`.
  - `out_count` <= `out_count`+1, modulo 2^16.
- Back-to-back strobes:
  - Every strobe cycle is captured.
  - The last write to a slot wins.
  - Strobes to different slots in consecutive cycles both land.
- X handling: `outsel` is don't-care while `outdisplay`=0; X on it must not corrupt any slot.
- Scan counters:
  - The prescaler counts 0..`SCAN_DIV`-1.
  - On wrap, the digit counter `dig` advances 0..7 and wraps 7→0.
- Digit decode:
  - Digit d shows nibble (d mod 4) of slot 2·`page_sel`+(d div 4).
  - Nibble 0 is [3:0]; digit 0 is rightmost.
  - Hex font covers 0-F; the dp segment is always off (1).
- Blank: if the slot shown by digit d has `valid`=0, `seg`=8'hFF for that digit.
- Output registration: each cycle, `digit_sel` <= ~(1<<`dig`), and `seg` <= font(nibble) computed from current `dig`, slot contents and `page_sel`.
- Page change: `page_sel` is sampled every cycle with no resynchronisation, and takes effect on the next `seg` update.

## Timing
- Reset values: `seg`=8'hFF, `digit_sel`=8'hFF, `led`=0, `out_count`=0, all slots 0, all `valid`=0, prescaler 0, `dig`=0.
- First clock after reset deassertion: `digit_sel`=8'hFE, and `seg`=8'hFF because the slot is invalid.
- Capture latency:
  - The slot, `led` and `out_count` update on the strobe edge.
  - If the captured slot is currently scanned, `seg` reflects the new value one edge later.
- Digit dwell: exactly `SCAN_DIV` cycles per digit; a full frame is 8·`SCAN_DIV` cycles.
- Strobes do not disturb the scan counters.
- Reset asserted mid-frame or mid-capture:
  - All state returns to reset values immediately, without waiting for a clock.
  - A strobe coincident with reset is discarded.

## Test plan
- Reset check (`SCAN_DIV`=4):
  - Hold `reset`, then release → `seg`=8'hFF and `digit_sel`=8'hFF during reset.
  - After release, `digit_sel` walks FE,FD,FB,…,7F, each for 4 cycles, then returns to FE.
  - `seg` stays FF throughout.
- Single capture: `outsel`=1, `outval1`=16'hBEEF, `outval2`=16'h1234, one strobe, `page_sel`=0 →
  - `led`=16'h1234 and `out_count`=1.
  - Digits 7..4 show B,E,E,F (segment codes 83,86,86,8E); digits 3..0 blank.
- Back-to-back captures: strobes in consecutive cycles for (slot 0, 16'h0001), (slot 0, 16'h0002), (slot 2, 16'hA5A5) →
  - Slot 0 = 16'h0002 and `out_count`=3.
  - `page_sel`=1 shows A5A5 on digits 3..0 and blank on digits 7..4.
- Wrap: preload 65535 strobes, then one more → `out_count` reads 0; slot contents unaffected.
- Async reset mid-frame: assert `reset` between clock edges while digit 5 is lit with a strobe pending →
  - Outputs go to reset values before the next edge.
  - The strobe is not captured.
- X immunity: `outdisplay`=0 with `outsel`=3'bXXX for 100 cycles → all slots, `valid`, `led` and `out_count` unchanged and free of X.

Source files
------------

// File: rtl/out_display_unit.sv
// Output stage for the processor OUT path: eight capture slots, an LED bank,
// and a hex 7-segment scanner that shows two slots per page.
module out_display_unit #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] outval1,
  input  logic [15:0] outval2,
  input  logic [2:0]  outsel,
  input  logic        outdisplay,
  input  logic [1:0]  page_sel,
  output logic [7:0]  seg,
  output logic [7:0]  digit_sel,
  output logic [15:0] led,
  output logic [15:0] out_count
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned SLOTS  = 8;
  localparam int unsigned DIG_W  = 3;
  localparam int unsigned SEG_W  = 8;
  localparam int unsigned PRE_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PRE_W-1:0]  r_pre;
  logic [DIG_W-1:0]  r_dig;
  logic [DATA_W-1:0] r_slot [SLOTS];
  logic [SLOTS-1:0]  r_valid;
  logic [DATA_W-1:0] r_led;
  logic [DATA_W-1:0] r_count;
  logic [SEG_W-1:0]  r_seg;
  logic [SEG_W-1:0]  r_digit_sel;

  logic              w_pre_wrap;
  logic [SLOTS-1:0]  w_wr_en;
  logic [2:0]        w_slot_idx;
  logic [DATA_W-1:0] w_slot_word;
  logic [3:0]        w_nib;
  logic [SEG_W-1:0]  w_font;
  logic [SEG_W-1:0]  w_seg_next;

  assign w_pre_wrap = (r_pre == PRE_W'(SCAN_DIV - 1));

  // Prescaler and digit counter; independent of captures.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pre <= '0;
      r_dig <= '0;
    end else if (w_pre_wrap) begin
      r_pre <= '0;
      r_dig <= r_dig + DIG_W'(1);
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  // Write enables are qualified by the strobe so an X select cannot reach a slot.
  always_comb begin
    w_wr_en = '0;
    for (int i = 0; i < SLOTS; i++) begin
      w_wr_en[i] = outdisplay && (outsel == 3'(i));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SLOTS; i++) begin
        r_slot[i] <= '0;
      end
      r_valid <= '0;
    end else begin
      for (int i = 0; i < SLOTS; i++) begin
        if (w_wr_en[i]) begin
          r_slot[i]  <= outval1;
          r_valid[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_led   <= '0;
      r_count <= '0;
    end else if (outdisplay) begin
      r_led   <= outval2;
      r_count <= r_count + DATA_W'(1);
    end
  end

  // Digits 7..4 show the odd slot of the page, digits 3..0 the even slot.
  always_comb begin
    w_slot_idx  = {page_sel, r_dig[2]};
    w_slot_word = r_slot[w_slot_idx];
    w_nib       = w_slot_word[{r_dig[1:0], 2'b00} +: 4];
  end

  // Active-low hex font, {dp,g,f,e,d,c,b,a}, dp held off.
  always_comb begin
    w_font = 8'hFF;
    case (w_nib)
      4'h0: w_font = 8'hC0;
      4'h1: w_font = 8'hF9;
      4'h2: w_font = 8'hA4;
      4'h3: w_font = 8'hB0;
      4'h4: w_font = 8'h99;
      4'h5: w_font = 8'h92;
      4'h6: w_font = 8'h82;
      4'h7: w_font = 8'hF8;
      4'h8: w_font = 8'h80;
      4'h9: w_font = 8'h90;
      4'hA: w_font = 8'h88;
      4'hB: w_font = 8'h83;
      4'hC: w_font = 8'hC6;
      4'hD: w_font = 8'hA1;
      4'hE: w_font = 8'h86;
      4'hF: w_font = 8'h8E;
      default: w_font = 8'hFF;
    endcase
  end

  always_comb begin
    w_seg_next = r_valid[w_slot_idx] ? w_font : 8'hFF;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_seg       <= 8'hFF;
      r_digit_sel <= 8'hFF;
    end else begin
      r_seg       <= w_seg_next;
      r_digit_sel <= ~(SEG_W'(1) << r_dig);
    end
  end

  assign seg       = r_seg;
  assign digit_sel = r_digit_sel;
  assign led       = r_led;
  assign out_count = r_count;

endmodule

// File: tb/tb_out_display_unit.sv
// Directed self-checking bench for out_display_unit with a short scan period.
module tb_out_display_unit;

  localparam int unsigned SD = 4;

  logic        clock;
  logic        reset;
  logic [15:0] outval1;
  logic [15:0] outval2;
  logic [2:0]  outsel;
  logic        outdisplay;
  logic [1:0]  page_sel;
  logic [7:0]  seg;
  logic [7:0]  digit_sel;
  logic [15:0] led;
  logic [15:0] out_count;

  int checks;
  int errors;
  int cyc;

  logic [15:0] m_slot [8];
  logic [7:0]  m_valid;
  logic [15:0] m_led;
  logic [15:0] m_count;

  out_display_unit #(.SCAN_DIV(SD)) dut (
    .clock(clock), .reset(reset), .outval1(outval1), .outval2(outval2),
    .outsel(outsel), .outdisplay(outdisplay), .page_sel(page_sel),
    .seg(seg), .digit_sel(digit_sel), .led(led), .out_count(out_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Edges since reset release; the expected lit digit is derived from it.
  always @(posedge clock or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  function automatic logic [7:0] font(input logic [3:0] n);
    case (n)
      4'h0: font = 8'hC0; 4'h1: font = 8'hF9; 4'h2: font = 8'hA4; 4'h3: font = 8'hB0;
      4'h4: font = 8'h99; 4'h5: font = 8'h92; 4'h6: font = 8'h82; 4'h7: font = 8'hF8;
      4'h8: font = 8'h80; 4'h9: font = 8'h90; 4'hA: font = 8'h88; 4'hB: font = 8'h83;
      4'hC: font = 8'hC6; 4'hD: font = 8'hA1; 4'hE: font = 8'h86; default: font = 8'h8E;
    endcase
  endfunction

  function automatic int unsigned cur_dig();
    cur_dig = ((cyc - 1) / SD) % 8;
  endfunction

  function automatic logic [7:0] exp_ds(input int unsigned d);
    logic [7:0] one;
    one = 8'd1;
    exp_ds = ~(one << d);
  endfunction

  function automatic logic [7:0] exp_seg(input int unsigned d);
    logic [2:0] idx;
    logic [3:0] nib;
    idx = 3'(32'(page_sel) * 2 + d / 4);
    nib = 4'(m_slot[idx] >> (4 * (d % 4)));
    exp_seg = m_valid[idx] ? font(nib) : 8'hFF;
  endfunction

  task automatic apply_reset();
    reset = 1'b1; outdisplay = 1'b0; outsel = 3'd0; outval1 = '0; outval2 = '0; page_sel = 2'd0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) m_slot[i] = '0;
    m_valid = '0; m_led = '0; m_count = '0;
  endtask

  // Drives one strobe cycle; outdisplay stays high until the caller drops it.
  task automatic strobe(input logic [2:0] sel, input logic [15:0] v1, input logic [15:0] v2);
    outsel = sel; outval1 = v1; outval2 = v2; outdisplay = 1'b1;
    @(posedge clock);
    #1;
    m_slot[sel] = v1; m_valid[sel] = 1'b1; m_led = v2; m_count = m_count + 16'd1;
  endtask

  task automatic idle();
    outdisplay = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; outdisplay = 1'b0; outsel = 3'd0; outval1 = '0; outval2 = '0; page_sel = 2'd0;
    @(posedge clock);
    #1;
    checks++;
    if (seg !== 8'hFF || digit_sel !== 8'hFF) begin
      errors++;
      $display("FAIL reset_disp: seg=%h digit_sel=%h required FF FF", seg, digit_sel);
    end
    checks++;
    if (led !== 16'h0 || out_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_regs: led=%h out_count=%h required 0 0", led, out_count);
    end
    reset = 1'b0;
    for (int i = 0; i < 8; i++) m_slot[i] = '0;
    m_valid = '0; m_led = '0; m_count = '0;
    for (int k = 0; k < 8 * SD + 2; k++) begin
      @(posedge clock);
      #1;
      checks++;
      if (digit_sel !== exp_ds(cur_dig()) || seg !== 8'hFF) begin
        errors++;
        $display("FAIL reset_scan cyc %0d: digit_sel=%h seg=%h required %h FF",
                 cyc, digit_sel, seg, exp_ds(cur_dig()));
      end
    end
  endtask

  task automatic test_single_capture();
    apply_reset();
    strobe(3'd1, 16'hBEEF, 16'h1234);
    checks++;
    if (led !== 16'h1234 || out_count !== 16'd1) begin
      errors++;
      $display("FAIL single_regs: led=%h out_count=%h required 1234 0001", led, out_count);
    end
    idle();
    for (int k = 0; k < 8 * SD + 1; k++) begin
      @(posedge clock);
      #1;
      checks++;
      if (digit_sel !== exp_ds(cur_dig()) || seg !== exp_seg(cur_dig())) begin
        errors++;
        $display("FAIL single_disp dig %0d: digit_sel=%h seg=%h required %h %h",
                 cur_dig(), digit_sel, seg, exp_ds(cur_dig()), exp_seg(cur_dig()));
      end
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    strobe(3'd0, 16'h0001, 16'h1111);
    strobe(3'd0, 16'h0002, 16'h2222);
    strobe(3'd2, 16'hA5A5, 16'h3333);
    checks++;
    if (out_count !== 16'd3 || led !== 16'h3333) begin
      errors++;
      $display("FAIL b2b_regs: out_count=%h led=%h required 0003 3333", out_count, led);
    end
    for (int p = 0; p < 2; p++) begin
      page_sel = 2'(p);
      idle();
      for (int k = 0; k < 8 * SD; k++) begin
        @(posedge clock);
        #1;
        checks++;
        if (seg !== exp_seg(cur_dig())) begin
          errors++;
          $display("FAIL b2b_disp page %0d dig %0d: seg=%h required %h",
                   p, cur_dig(), seg, exp_seg(cur_dig()));
        end
      end
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    strobe(3'd4, 16'hCAFE, 16'h0044);
    outsel = 3'd5; outval1 = 16'h5A5A; outval2 = 16'h0055; outdisplay = 1'b1;
    repeat (65534) @(posedge clock);
    #1;
    m_slot[5] = 16'h5A5A; m_valid[5] = 1'b1; m_led = 16'h0055; m_count = m_count + 16'd65534;
    checks++;
    if (out_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_pre: out_count=%h required FFFF", out_count);
    end
    strobe(3'd5, 16'h5A5A, 16'h0066);
    checks++;
    if (out_count !== 16'h0000 || led !== 16'h0066) begin
      errors++;
      $display("FAIL wrap_zero: out_count=%h led=%h required 0000 0066", out_count, led);
    end
    page_sel = 2'd2;
    idle();
    for (int k = 0; k < 8 * SD; k++) begin
      @(posedge clock);
      #1;
      checks++;
      if (seg !== exp_seg(cur_dig())) begin
        errors++;
        $display("FAIL wrap_disp dig %0d: seg=%h required %h", cur_dig(), seg, exp_seg(cur_dig()));
      end
    end
  endtask

  task automatic test_async_reset();
    int unsigned guard;
    apply_reset();
    page_sel = 2'd1;
    strobe(3'd3, 16'h4321, 16'h0777);
    idle();
    guard = 0;
    while (cur_dig() != 5 && guard < 100) begin
      @(posedge clock);
      #1;
      guard++;
    end
    checks++;
    if (guard >= 100 || digit_sel !== 8'hDF || seg !== 8'hA4) begin
      errors++;
      $display("FAIL async_pre: digit_sel=%h seg=%h required DF A4", digit_sel, seg);
    end
    outsel = 3'd0; outval1 = 16'hFFFF; outval2 = 16'hBBBB; outdisplay = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (seg !== 8'hFF || digit_sel !== 8'hFF || led !== 16'h0 || out_count !== 16'h0) begin
      errors++;
      $display("FAIL async_now: seg=%h digit_sel=%h led=%h out_count=%h required FF FF 0 0",
               seg, digit_sel, led, out_count);
    end
    @(posedge clock);
    #1;
    outdisplay = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) m_slot[i] = '0;
    m_valid = '0; m_led = '0; m_count = '0;
    page_sel = 2'd0;
    checks++;
    if (led !== 16'h0 || out_count !== 16'h0) begin
      errors++;
      $display("FAIL async_strobe: led=%h out_count=%h required 0 0", led, out_count);
    end
    for (int p = 0; p < 2; p++) begin
      page_sel = 2'(p);
      idle();
      for (int k = 0; k < 8 * SD; k++) begin
        @(posedge clock);
        #1;
        checks++;
        if (seg !== 8'hFF || digit_sel !== exp_ds(cur_dig())) begin
          errors++;
          $display("FAIL async_post page %0d dig %0d: seg=%h digit_sel=%h required FF %h",
                   p, cur_dig(), seg, digit_sel, exp_ds(cur_dig()));
        end
      end
    end
  endtask

  task automatic test_x_immunity();
    apply_reset();
    strobe(3'd6, 16'h0F0F, 16'h7777);
    outdisplay = 1'b0; outsel = 3'bxxx; outval1 = 16'hxxxx;
    repeat (100) @(posedge clock);
    #1;
    checks++;
    if (led !== 16'h7777 || out_count !== 16'd1) begin
      errors++;
      $display("FAIL x_regs: led=%h out_count=%h required 7777 0001", led, out_count);
    end
    for (int p = 0; p < 4; p++) begin
      page_sel = 2'(p);
      idle();
      for (int k = 0; k < 8 * SD; k++) begin
        @(posedge clock);
        #1;
        checks++;
        if (seg !== exp_seg(cur_dig())) begin
          errors++;
          $display("FAIL x_disp page %0d dig %0d: seg=%h required %h",
                   p, cur_dig(), seg, exp_seg(cur_dig()));
        end
      end
    end
    outsel = 3'd0; outval1 = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_capture();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    test_x_immunity();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
